alu_result_checker: RTL

//  Self-checking monitor at the consumer end of the ALU interface: samples each (A,B,ALUFun,Sign,S)

---
 rtl/alu_result_checker.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker: passive monitor beside the ALU. Each transaction is
// captured in a stage register, its golden result is recomputed on the next
// cycle and compared with the ALU's S. Pass/fail/illegal events are counted in
// saturating counters, and the first failing transaction is held for debug.
module alu_result_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             in_valid_i,
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    input  logic [5:0]       alu_fun_i,
    input  logic             sign_i,
    input  logic [31:0]      s_i,
    output logic             chk_valid_o,
    output logic             chk_pass_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] ill_cnt_o,
    output logic             err_o,
    output logic [31:0]      ff_a_o,
    output logic [31:0]      ff_b_o,
    output logic [5:0]       ff_fun_o,
    output logic [31:0]      ff_s_o,
    output logic [31:0]      ff_exp_o
);

    // Stage register holding the transaction under check
    logic             st_valid_q, st_valid_d;
    logic [31:0]      st_a_q, st_a_d;
    logic [31:0]      st_b_q, st_b_d;
    logic [5:0]       st_fun_q, st_fun_d;
    logic             st_sign_q, st_sign_d;
    logic [31:0]      st_s_q, st_s_d;

    // Check results, counters and first-failure capture
    logic             chk_valid_q, chk_valid_d;
    logic             chk_pass_q, chk_pass_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             err_q, err_d;
    logic [31:0]      ff_a_q, ff_a_d;
    logic [31:0]      ff_b_q, ff_b_d;
    logic [5:0]       ff_fun_q, ff_fun_d;
    logic [31:0]      ff_s_q, ff_s_d;
    logic [31:0]      ff_exp_q, ff_exp_d;

    logic [31:0]        exp_val;
    logic               fun_legal;
    logic signed [31:0] sra_val;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign sra_val = $signed(st_b_q) >>> st_a_q[4:0];

    // Golden ALU result for the staged transaction; unknown codes flag illegal
    always_comb begin
        exp_val   = '0;
        fun_legal = 1'b1;
        case (st_fun_q)
            6'b000000: exp_val = st_a_q + st_b_q;
            6'b000001: exp_val = st_a_q - st_b_q;
            6'b011000: exp_val = st_a_q & st_b_q;
            6'b011110: exp_val = st_a_q | st_b_q;
            6'b010110: exp_val = st_a_q ^ st_b_q;
            6'b010001: exp_val = ~(st_a_q | st_b_q);
            6'b011010: exp_val = st_a_q;
            6'b100000: exp_val = st_b_q << st_a_q[4:0];
            6'b100001: exp_val = st_b_q >> st_a_q[4:0];
            6'b100011: exp_val = sra_val;
            6'b110011: exp_val = {31'b0, st_a_q == st_b_q};
            6'b110001: exp_val = {31'b0, st_a_q != st_b_q};
            6'b110101: exp_val = {31'b0, st_sign_q ? ($signed(st_a_q) < $signed(st_b_q))
                                                   : (st_a_q < st_b_q)};
            6'b111101: exp_val = {31'b0, st_a_q[31] | (st_a_q == 32'd0)};
            6'b111011: exp_val = {31'b0, st_a_q[31]};
            6'b111111: exp_val = {31'b0, ~st_a_q[31] & (st_a_q != 32'd0)};
            default:   fun_legal = 1'b0;
        endcase
    end

    // Next state: capture new transaction, score the staged one; clr wins over both
    always_comb begin
        st_valid_d  = in_valid_i;
        st_a_d      = st_a_q;
        st_b_d      = st_b_q;
        st_fun_d    = st_fun_q;
        st_sign_d   = st_sign_q;
        st_s_d      = st_s_q;
        chk_valid_d = 1'b0;
        chk_pass_d  = 1'b0;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        err_d       = err_q;
        ff_a_d      = ff_a_q;
        ff_b_d      = ff_b_q;
        ff_fun_d    = ff_fun_q;
        ff_s_d      = ff_s_q;
        ff_exp_d    = ff_exp_q;

        if (in_valid_i) begin
            st_a_d    = a_i;
            st_b_d    = b_i;
            st_fun_d  = alu_fun_i;
            st_sign_d = sign_i;
            st_s_d    = s_i;
        end

        if (clr_i) begin
            st_valid_d = 1'b0;
            st_a_d     = '0;
            st_b_d     = '0;
            st_fun_d   = '0;
            st_sign_d  = 1'b0;
            st_s_d     = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            ill_cnt_d  = '0;
            err_d      = 1'b0;
            ff_a_d     = '0;
            ff_b_d     = '0;
            ff_fun_d   = '0;
            ff_s_d     = '0;
            ff_exp_d   = '0;
        end else if (st_valid_q) begin
            chk_valid_d = 1'b1;
            if (!fun_legal) begin
                chk_pass_d = 1'b1;
                ill_cnt_d  = sat_inc(ill_cnt_q);
            end else if (exp_val == st_s_q) begin
                chk_pass_d = 1'b1;
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                err_d      = 1'b1;
                if (!err_q) begin
                    ff_a_d   = st_a_q;
                    ff_b_d   = st_b_q;
                    ff_fun_d = st_fun_q;
                    ff_s_d   = st_s_q;
                    ff_exp_d = exp_val;
                end
            end
        end
    end

    // State registers; reset empties the pipeline and zeroes everything
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_valid_q  <= 1'b0;
            st_a_q      <= '0;
            st_b_q      <= '0;
            st_fun_q    <= '0;
            st_sign_q   <= 1'b0;
            st_s_q      <= '0;
            chk_valid_q <= 1'b0;
            chk_pass_q  <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            ill_cnt_q   <= '0;
            err_q       <= 1'b0;
            ff_a_q      <= '0;
            ff_b_q      <= '0;
            ff_fun_q    <= '0;
            ff_s_q      <= '0;
            ff_exp_q    <= '0;
        end else begin
            st_valid_q  <= st_valid_d;
            st_a_q      <= st_a_d;
            st_b_q      <= st_b_d;
            st_fun_q    <= st_fun_d;
            st_sign_q   <= st_sign_d;
            st_s_q      <= st_s_d;
            chk_valid_q <= chk_valid_d;
            chk_pass_q  <= chk_pass_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
            err_q       <= err_d;
            ff_a_q      <= ff_a_d;
            ff_b_q      <= ff_b_d;
            ff_fun_q    <= ff_fun_d;
            ff_s_q      <= ff_s_d;
            ff_exp_q    <= ff_exp_d;
        end
    end

    assign chk_valid_o = chk_valid_q;
    assign chk_pass_o  = chk_pass_q;
    assign pass_cnt_o  = pass_cnt_q;
    assign fail_cnt_o  = fail_cnt_q;
    assign ill_cnt_o   = ill_cnt_q;
    assign err_o       = err_q;
    assign ff_a_o      = ff_a_q;
    assign ff_b_o      = ff_b_q;
    assign ff_fun_o    = ff_fun_q;
    assign ff_s_o      = ff_s_q;
    assign ff_exp_o    = ff_exp_q;

endmodule
